mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request/response memory slave.
// It contains a 2^ADDR_W x 32-bit word RAM and one memory-mapped 8-bit LED register.
// Reads return data RD_LAT cycles after acceptance.
// Writes, and requests that are misaligned or hit no mapped location, respond one cycle after acceptance.
module mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          RD_LAT   = 2,
    parameter logic [31:0] LED_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  led
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // BUSY lasts RD_LAT-1 cycles; the counter is preloaded with one less than that.
    localparam int         BUSY_CYC  = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
    localparam logic [1:0] BUSY_INIT = BUSY_CYC[1:0];

    logic [1:0]        state_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic [7:0]        led_r;
    logic [1:0]        cnt_r;
    logic [ADDR_W-1:0] idx_r;
    logic              is_led_r;
    logic [31:0]       mem_r [0:(2**ADDR_W)-1];

    logic              misalign_s;
    logic              led_hit_s;
    logic              ram_hit_s;
    logic              err_s;
    logic              accept_s;
    logic              ram_wr_s;
    logic [ADDR_W-1:0] req_idx_s;

    // Decode the presented request: alignment, target and acceptance.
    always_comb begin
        misalign_s = (req_addr[1:0] != 2'b00);
        led_hit_s  = (req_addr == LED_ADDR);
        ram_hit_s  = (req_addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
        err_s      = misalign_s | ~(led_hit_s | ram_hit_s);
        req_idx_s  = req_addr[ADDR_W+1:2];
        accept_s   = req_valid & req_ready_r & ~rst;
        if (accept_s && req_we && !err_s && !led_hit_s) begin
            ram_wr_s = 1'b1;
        end else begin
            ram_wr_s = 1'b0;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            mem_r[req_idx_s] <= req_wdata;
        end
    end

    // Request/response FSM with registered response and LED outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            led_r        <= 8'h00;
            cnt_r        <= 2'd0;
            idx_r        <= {ADDR_W{1'b0}};
            is_led_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        idx_r       <= req_idx_s;
                        is_led_r    <= led_hit_s;
                        req_ready_r <= 1'b0;
                        if (req_we || err_s) begin
                            // Writes and errors answer in the very next cycle with zero data.
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                            resp_err_r   <= err_s;
                            if (req_we && !err_s && led_hit_s) begin
                                led_r <= req_wdata[7:0];
                            end
                        end else if (RD_LAT == 1) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= led_hit_s ? {24'h00_0000, led_r} : mem_r[req_idx_s];
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= BUSY_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 2'd0) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= is_led_r ? {24'h00_0000, led_r} : mem_r[idx_r];
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign led        = led_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Three instances (RD_LAT = 1, 2, 4) share clock and reset; each has its own request inputs.
module tb_mem_responder;

    localparam logic [31:0] LED_A = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid_a = 3'b000;
    logic [2:0]  req_we_a    = 3'b000;
    logic [31:0] req_addr_a  [3];
    logic [31:0] req_wdata_a [3];
    logic [2:0]  req_ready_a;
    logic [2:0]  resp_valid_a;
    logic [31:0] resp_rdata_a [3];
    logic [2:0]  resp_err_a;
    logic [7:0]  led_a [3];

    int nerr = 0;
    int nchk = 0;

    logic [31:0] model_mem [3][1024];
    logic [7:0]  model_led [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .ADDR_W  (10),
            .RD_LAT  ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .LED_ADDR(LED_A)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid_a[g]),
            .req_ready (req_ready_a[g]),
            .req_we    (req_we_a[g]),
            .req_addr  (req_addr_a[g]),
            .req_wdata (req_wdata_a[g]),
            .resp_valid(resp_valid_a[g]),
            .resp_rdata(resp_rdata_a[g]),
            .resp_err  (resp_err_a[g]),
            .led       (led_a[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || !((a == LED_A) || (a < 32'h0000_1000));
    endfunction

    // One complete transaction on instance d, checked against the model.
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_data;
        int          k;
        bit          got;
        exp_err  = addr_err(addr);
        exp_lat  = (we || exp_err) ? 1 : lat_of(d);
        exp_data = 32'h0;
        if (!we && !exp_err) begin
            exp_data = (addr == LED_A) ? {24'h0, model_led[d]} : model_mem[d][addr[11:2]];
        end
        @(negedge clk);
        nchk++;
        if (req_ready_a[d] !== 1'b1) begin
            nerr++; $display("FAIL %s ready_before: got %b want 1", tag, req_ready_a[d]);
        end
        req_valid_a[d] = 1'b1; req_we_a[d] = we; req_addr_a[d] = addr; req_wdata_a[d] = wdata;
        @(posedge clk); #1;
        req_valid_a[d] = 1'b0;
        req_addr_a[d] = $urandom(); req_wdata_a[d] = $urandom(); req_we_a[d] = $urandom_range(0, 1);
        if (we && !exp_err) begin
            if (addr == LED_A) model_led[d] = wdata[7:0];
            else model_mem[d][addr[11:2]] = wdata;
        end
        got = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid_a[d] === 1'b1) begin
                got = 1'b1;
                break;
            end
            nchk++;
            if (resp_rdata_a[d] !== 32'h0 || resp_err_a[d] !== 1'b0) begin
                nerr++; $display("FAIL %s idle_zero: rdata=%h err=%b want 0/0", tag, resp_rdata_a[d], resp_err_a[d]);
            end
        end
        nchk++;
        if (!got || k != exp_lat) begin
            nerr++; $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, k, got, exp_lat);
        end
        nchk++;
        if (resp_rdata_a[d] !== exp_data) begin
            nerr++; $display("FAIL %s rdata: got %h want %h", tag, resp_rdata_a[d], exp_data);
        end
        nchk++;
        if (resp_err_a[d] !== exp_err) begin
            nerr++; $display("FAIL %s err: got %b want %b", tag, resp_err_a[d], exp_err);
        end
        nchk++;
        if (led_a[d] !== model_led[d]) begin
            nerr++; $display("FAIL %s led: got %h want %h", tag, led_a[d], model_led[d]);
        end
        @(negedge clk);
        nchk++;
        if (resp_valid_a[d] !== 1'b0 || resp_rdata_a[d] !== 32'h0 || resp_err_a[d] !== 1'b0 || req_ready_a[d] !== 1'b1) begin
            nerr++; $display("FAIL %s after_resp: valid=%b rdata=%h err=%b ready=%b want 0/0/0/1",
                             tag, resp_valid_a[d], resp_rdata_a[d], resp_err_a[d], req_ready_a[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        // A request presented during reset must be ignored.
        @(negedge clk);
        req_valid_a[1] = 1'b1; req_we_a[1] = 1'b1; req_addr_a[1] = LED_A; req_wdata_a[1] = 32'h0000_00FF;
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if (req_ready_a[d] !== 1'b1 || resp_valid_a[d] !== 1'b0 || resp_rdata_a[d] !== 32'h0 ||
                resp_err_a[d] !== 1'b0 || led_a[d] !== 8'h00) begin
                nerr++; $display("FAIL reset_state[%0d]: ready=%b valid=%b rdata=%h err=%b led=%h want 1/0/0/0/00",
                                 d, req_ready_a[d], resp_valid_a[d], resp_rdata_a[d], resp_err_a[d], led_a[d]);
            end
            model_led[d] = 8'h00;
        end
        rst = 1'b0;
        @(negedge clk);
        nchk++;
        if (led_a[1] !== 8'h00 || resp_valid_a[1] !== 1'b0) begin
            nerr++; $display("FAIL reset_ignore_req: led=%h valid=%b want 00/0", led_a[1], resp_valid_a[1]);
        end
    endtask

    task automatic test_basic(input int d);
        do_req(d, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "basic_wr");
        do_req(d, 1'b0, 32'h0000_0010, 32'h0, "basic_rd");
    endtask

    task automatic test_led();
        do_req(1, 1'b1, 32'h0000_0F00, 32'h1357_9BDF, "led_pre");
        do_req(1, 1'b1, LED_A, 32'h0000_00A5, "led_wr");
        do_req(1, 1'b0, LED_A, 32'h0, "led_rd");
        do_req(1, 1'b0, 32'h0000_0F00, 32'h0, "led_ram_untouched");
    endtask

    task automatic test_errors();
        do_req(1, 1'b0, 32'h0000_0012, 32'h0, "err_misalign_rd");
        do_req(1, 1'b0, 32'h0000_1000, 32'h0, "err_range_rd");
        do_req(1, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, "err_pre");
        do_req(1, 1'b1, 32'h0000_0011, 32'h1111_1111, "err_misalign_wr");
        do_req(1, 1'b1, 32'h0000_1000, 32'h2222_2222, "err_range_wr");
        do_req(1, 1'b1, LED_A + 32'd1, 32'h0000_0033, "err_led_misalign");
        do_req(1, 1'b0, 32'h0000_0010, 32'h0, "err_chk_10");
        do_req(1, 1'b0, 32'h0000_0000, 32'h0, "err_chk_0");
        do_req(1, 1'b0, LED_A, 32'h0, "err_chk_led");
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] addrs [4];
        logic [31:0] exp_q [$];
        int          acc_cyc [$];
        int          n_resp;
        bit          prev_v;
        bit          acc;
        int          ncyc;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = 32'h0000_0200 + 32'(i * 4);
            do_req(d, 1'b1, addrs[i], $urandom(), "b2b_pre");
            exp_q.push_back(model_mem[d][addrs[i][11:2]]);
        end
        n_resp = 0; prev_v = 1'b0;
        ncyc = 4 * (lat_of(d) + 1) + 4;
        @(negedge clk);
        req_valid_a[d] = 1'b1; req_we_a[d] = 1'b0; req_addr_a[d] = addrs[0];
        for (int c = 0; c < ncyc; c++) begin
            acc = (req_ready_a[d] === 1'b1) && req_valid_a[d];
            if (resp_valid_a[d] === 1'b1) begin
                nchk++;
                if (prev_v) begin
                    nerr++; $display("FAIL b2b_width[%0d]: resp_valid high two cycles", d);
                end
                nchk++;
                if (n_resp < 4 && resp_rdata_a[d] !== exp_q[n_resp]) begin
                    nerr++; $display("FAIL b2b_rdata[%0d]: got %h want %h", d, resp_rdata_a[d], exp_q[n_resp]);
                end
                n_resp++;
            end
            prev_v = (resp_valid_a[d] === 1'b1);
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(c);
                if (acc_cyc.size() < 4) req_addr_a[d] = addrs[acc_cyc.size()];
                else req_valid_a[d] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid_a[d] = 1'b0;
        nchk++;
        if (n_resp != 4 || acc_cyc.size() != 4) begin
            nerr++; $display("FAIL b2b_count[%0d]: resp=%0d acc=%0d want 4/4", d, n_resp, acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            nchk++;
            if (acc_cyc[i] - acc_cyc[i-1] != lat_of(d) + 1) begin
                nerr++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", d, acc_cyc[i] - acc_cyc[i-1], lat_of(d) + 1);
            end
        end
    endtask

    task automatic test_reset_busy();
        do_req(1, 1'b1, 32'h0000_0040, 32'h1234_5678, "rb_pre");
        do_req(1, 1'b1, LED_A, 32'h0000_005A, "rb_led");
        @(negedge clk);
        req_valid_a[1] = 1'b1; req_we_a[1] = 1'b0; req_addr_a[1] = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid_a[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) model_led[d] = 8'h00;
        @(negedge clk);
        nchk++;
        if (req_ready_a[1] !== 1'b1 || led_a[1] !== 8'h00) begin
            nerr++; $display("FAIL rb_state: ready=%b led=%h want 1/00", req_ready_a[1], led_a[1]);
        end
        for (int i = 0; i < 5; i++) begin
            nchk++;
            if (resp_valid_a[1] !== 1'b0) begin
                nerr++; $display("FAIL rb_no_resp: resp_valid=%b want 0 (cycle %0d)", resp_valid_a[1], i);
            end
            @(negedge clk);
        end
        do_req(1, 1'b0, 32'h0000_0040, 32'h0, "rb_ram_kept");
        // A write accepted at the same edge as reset must not land.
        @(negedge clk);
        rst = 1'b1;
        req_valid_a[1] = 1'b1; req_we_a[1] = 1'b1; req_addr_a[1] = 32'h0000_0040; req_wdata_a[1] = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        rst = 1'b0; req_valid_a[1] = 1'b0;
        do_req(1, 1'b0, 32'h0000_0040, 32'h0, "rb_wr_dropped");
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] addr;
        int          kind;
        for (int i = 0; i < 8; i++) do_req(d, 1'b1, 32'h0000_0100 + 32'(i * 4), $urandom(), "rnd_pre");
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            addr = 32'h0000_0100 + 32'($urandom_range(0, 7) * 4);
            if (kind == 6) addr = LED_A;
            else if (kind == 7) addr = addr + 32'($urandom_range(1, 3));
            else if (kind == 8) begin
                addr = ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
                if (addr == LED_A) addr = 32'h0000_2000;
            end
            do_req(d, 1'($urandom_range(0, 1)), addr, $urandom(), "rnd");
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_addr_a[d] = 32'h0; req_wdata_a[d] = 32'h0; model_led[d] = 8'h00;
        end
        test_reset();
        test_basic(1);
        test_basic(0);
        test_basic(2);
        test_led();
        test_errors();
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_busy();
        test_random(0, 25);
        test_random(1, 25);
        test_random(2, 25);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
